// File: rtl/pll_ctrl_pkg.sv
// Shared state encoding and default constants for the PLL lock control blocks.
package pll_ctrl_pkg;

  localparam int DEF_PHASE_BITS  = 32;
  localparam int DEF_LG_START    = 4;
  localparam int DEF_LG_FINAL    = 10;
  localparam int DEF_WINDOW      = 64;
  localparam int DEF_LOCK_THRESH = 4;
  localparam int DEF_MAX_RETRY   = 3;
  localparam int LG_BITS         = 5;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_ACQUIRE = 3'd2,
    ST_LOCKED  = 3'd3,
    ST_FAIL    = 3'd4
  } pll_state_t;

  // Window and error counters only run while the loop is being evaluated.
  function automatic logic is_counting(pll_state_t s);
    return (s == ST_ACQUIRE) || (s == ST_LOCKED);
  endfunction

endpackage

// File: rtl/pll_err_window.sv
// Counts cycles of an evaluation window and the error cycles inside it.
module pll_err_window
  import pll_ctrl_pkg::*;
#(
  parameter int WINDOW = DEF_WINDOW,
  parameter int CW     = $clog2(WINDOW + 1)
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          clear,
  input  logic          err,
  output logic          window_done,
  output logic [CW-1:0] err_total
);

  logic [CW-1:0] win_cnt;
  logic [CW-1:0] err_cnt;

  // err_total already includes the current cycle so the last cycle counts.
  always_comb begin
    window_done = !clear && (win_cnt == CW'(WINDOW - 1));
    if (err && (err_cnt != CW'(WINDOW))) begin
      err_total = err_cnt + CW'(1);
    end else begin
      err_total = err_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (nrst || clear || window_done) begin
      win_cnt <= '0;
      err_cnt <= '0;
    end else begin
      win_cnt <= win_cnt + CW'(1);
      err_cnt <= err_total;
    end
  end

endmodule

// File: rtl/pll_lock_sequencer.sv
// Steps a PLL from wide to narrow loop bandwidth, declaring lock or giving up
// after repeated failed acquisition windows.
module pll_lock_sequencer
  import pll_ctrl_pkg::*;
#(
  parameter int PHASE_BITS  = DEF_PHASE_BITS,
  parameter int LG_START    = DEF_LG_START,
  parameter int LG_FINAL    = DEF_LG_FINAL,
  parameter int WINDOW      = DEF_WINDOW,
  parameter int LOCK_THRESH = DEF_LOCK_THRESH,
  parameter int MAX_RETRY   = DEF_MAX_RETRY
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  swipt_alive,
  input  logic                  start,
  input  logic [PHASE_BITS-2:0] init_freq,
  input  logic [1:0]            pll_error,
  output logic                  load_freq,
  output logic [PHASE_BITS-2:0] freq,
  output logic [LG_BITS-1:0]    lgcoefficient,
  output logic                  locked,
  output logic                  fail,
  output logic [2:0]            state
);

  localparam int CW = $clog2(WINDOW + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam logic [LG_BITS-1:0] LG_START_W = LG_BITS'(LG_START);
  localparam logic [LG_BITS-1:0] LG_FINAL_W = LG_BITS'(LG_FINAL);
  localparam logic [RW-1:0]      RETRY_LAST = RW'(MAX_RETRY - 1);

  pll_state_t            cur_state;
  pll_state_t            nxt_state;
  logic [RW-1:0]         retry_cnt;
  logic [RW-1:0]         retry_nxt;
  logic                  load_nxt;
  logic                  locked_nxt;
  logic                  fail_nxt;
  logic [PHASE_BITS-2:0] freq_nxt;
  logic [LG_BITS-1:0]    lg_nxt;
  logic                  win_clear;
  logic                  err_cycle;
  logic                  window_done;
  logic [CW-1:0]         err_total;
  logic [31:0]           err_sum;
  logic                  win_pass;
  logic                  win_drop;
  logic                  at_final;

  assign win_clear = !swipt_alive || !is_counting(cur_state);
  assign err_cycle = (pll_error != 2'b00);

  pll_err_window #(
    .WINDOW (WINDOW),
    .CW     (CW)
  ) u_err_window (
    .clk         (clk),
    .nrst        (nrst),
    .clear       (win_clear),
    .err         (err_cycle),
    .window_done (window_done),
    .err_total   (err_total)
  );

  assign err_sum  = 32'(err_total);
  assign win_pass = err_sum <= 32'(LOCK_THRESH);
  assign win_drop = err_sum > 32'(2 * LOCK_THRESH);
  assign at_final = lgcoefficient >= LG_FINAL_W;
  assign state    = cur_state;

  // All outputs are registered here alongside the state.
  always_ff @(posedge clk) begin
    if (nrst) begin
      cur_state     <= ST_IDLE;
      load_freq     <= 1'b0;
      freq          <= '0;
      lgcoefficient <= LG_START_W;
      locked        <= 1'b0;
      fail          <= 1'b0;
      retry_cnt     <= '0;
    end else begin
      cur_state     <= nxt_state;
      load_freq     <= load_nxt;
      freq          <= freq_nxt;
      lgcoefficient <= lg_nxt;
      locked        <= locked_nxt;
      fail          <= fail_nxt;
      retry_cnt     <= retry_nxt;
    end
  end

  // Loss of the power link overrides both start and window evaluation.
  always_comb begin
    nxt_state = cur_state;
    if (!swipt_alive) begin
      nxt_state = ST_IDLE;
    end else begin
      case (cur_state)
        ST_IDLE, ST_FAIL: if (start) nxt_state = ST_LOAD;
        ST_LOAD:          nxt_state = ST_ACQUIRE;
        ST_ACQUIRE: begin
          if (window_done) begin
            if (win_pass) nxt_state = at_final ? ST_LOCKED : ST_ACQUIRE;
            else          nxt_state = (retry_cnt >= RETRY_LAST) ? ST_FAIL : ST_LOAD;
          end
        end
        ST_LOCKED: if (window_done && win_drop) nxt_state = ST_ACQUIRE;
        default:   nxt_state = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    load_nxt   = (nxt_state == ST_LOAD);
    freq_nxt   = load_nxt ? init_freq : freq;
    locked_nxt = (nxt_state == ST_LOCKED);
    fail_nxt   = fail;
    lg_nxt     = load_nxt ? LG_START_W : lgcoefficient;
    retry_nxt  = retry_cnt;
    if (nxt_state == ST_FAIL) fail_nxt = 1'b1;
    else if (load_nxt)        fail_nxt = 1'b0;
    if (swipt_alive) begin
      case (cur_state)
        ST_IDLE, ST_FAIL: if (start) retry_nxt = '0;
        ST_ACQUIRE: begin
          if (window_done) begin
            if (!win_pass)      retry_nxt = retry_cnt + RW'(1);
            else if (!at_final) lg_nxt    = lgcoefficient + LG_BITS'(1);
          end
        end
        // Losing lock restarts acquisition without reloading the frequency.
        ST_LOCKED: begin
          if (window_done && win_drop) begin
            lg_nxt    = LG_START_W;
            retry_nxt = '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench: a window-level model predicts every visible output change
// of the sequencer and a monitor matches them against the DUT cycle by cycle.
module tb_pll_lock_sequencer;

  localparam int W  = 64;
  localparam int LS = 4;
  localparam int LF = 10;
  localparam int LT = 4;
  localparam int MR = 3;
  localparam int FW = 31;
  localparam int N  = 4200;

  localparam int S_IDLE = 0, S_LOAD = 1, S_ACQ = 2, S_LOCKED = 3, S_FAIL = 4;

  typedef struct packed {
    logic [2:0]    st;
    logic          lf;
    logic [4:0]    lg;
    logic          lk;
    logic          fl;
    logic [FW-1:0] fq;
  } snap_t;

  typedef struct {
    int    e;
    snap_t s;
  } exp_t;

  localparam snap_t RESET_SNAP = '{st: 3'd0, lf: 1'b0, lg: 5'd4, lk: 1'b0, fl: 1'b0, fq: '0};

  logic          clk = 1'b0;
  logic          nrst, swipt_alive, start;
  logic [FW-1:0] init_freq;
  logic [1:0]    pll_error;
  logic          load_freq, locked, fail;
  logic [FW-1:0] freq;
  logic [4:0]    lgcoefficient;
  logic [2:0]    state;

  pll_lock_sequencer dut (
    .clk           (clk),
    .nrst          (nrst),
    .swipt_alive   (swipt_alive),
    .start         (start),
    .init_freq     (init_freq),
    .pll_error     (pll_error),
    .load_freq     (load_freq),
    .freq          (freq),
    .lgcoefficient (lgcoefficient),
    .locked        (locked),
    .fail          (fail),
    .state         (state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit            r_at [0:N+W];
  bit            a_at [0:N+W];
  bit            s_at [0:N+W];
  logic [1:0]    e_at [0:N+W];
  logic [FW-1:0] f_at [0:N+W];
  int            gpos;

  exp_t  exp_q[$];
  int    n_checks = 0;
  int    n_fail = 0;
  bit    done = 1'b0;
  snap_t mon_prev = RESET_SNAP;

  int            m_st, m_lg, m_retry, m_ws;
  logic          m_lf, m_lk, m_fl;
  logic [FW-1:0] m_fq;
  snap_t         m_prev;

  function automatic string show(snap_t s);
    return $sformatf("st=%0d lf=%0b lg=%0d lk=%0b fl=%0b fq=%h", s.st, s.lf, s.lg, s.lk, s.fl, s.fq);
  endfunction

  function automatic void mark_err(int k);
    e_at[k] = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b11;
  endfunction

  function automatic void gen_start();
    s_at[gpos] = 1'b1;
    gpos += 2;
  endfunction

  // One evaluation window starting at gpos with exactly nerr error cycles.
  function automatic void gen_window(int nerr, bit on_last, bit glitch);
    int left = nerr;
    int slot;
    if (on_last && left > 0) begin
      mark_err(gpos + W - 1);
      left--;
    end
    while (left > 0) begin
      slot = gpos + $urandom_range(0, W - 2);
      if (e_at[slot] == 2'b00) begin
        mark_err(slot);
        left--;
      end
    end
    if (glitch) s_at[gpos + $urandom_range(0, W - 1)] = 1'b1;
    gpos += W;
  endfunction

  function automatic void build_stimulus();
    int p_tab [4] = '{0, 20, 60, 140};
    int p;
    for (int i = 0; i <= N + W; i++) begin
      r_at[i] = 1'b0;
      a_at[i] = 1'b1;
      s_at[i] = 1'b0;
      e_at[i] = 2'b00;
      f_at[i] = FW'($urandom);
    end
    for (int i = 1; i <= 3; i++) r_at[i] = 1'b1;
    gpos = 7;
    gen_start();
    for (int k = 0; k < 7; k++) gen_window(0, 1'b0, k[0]);
    gen_window(8, 1'b1, 1'b0);
    gen_window(9, 1'b1, 1'b0);
    gen_window(2, 1'b0, 1'b0);
    gpos += 20;
    a_at[gpos] = 1'b0;
    s_at[gpos] = 1'b1;
    gpos += 6;
    gen_start();
    gen_window(5, 1'b1, 1'b0);
    gpos += 1;
    gen_window(4, 1'b1, 1'b0);
    gen_window(5, 1'b0, 1'b0);
    gpos += 1;
    gen_window(6, 1'b0, 1'b0);
    gpos += 4;
    s_at[gpos] = 1'b1;
    r_at[gpos + 1] = 1'b1;
    gpos += 4;
    s_at[gpos] = 1'b1;
    for (int c = gpos; c <= N - 8; c += 128) begin
      p = p_tab[$urandom_range(0, 3)];
      for (int i = c; i < c + 128 && i <= N - 8; i++) begin
        if ($urandom_range(0, 999) < p) mark_err(i);
        if ($urandom_range(0, 149) == 0) s_at[i] = 1'b1;
        if ($urandom_range(0, 1499) == 0) a_at[i] = 1'b0;
        if ($urandom_range(0, 3999) == 0) r_at[i] = 1'b1;
      end
    end
  endfunction

  // Reference behaviour: whole windows are judged by summing their error cycles.
  task automatic model_step(input int e);
    int    total;
    snap_t nxt;
    exp_t  ev;
    if (r_at[e]) begin
      m_st = S_IDLE; m_lf = 1'b0; m_fq = '0; m_lg = LS;
      m_lk = 1'b0; m_fl = 1'b0; m_retry = 0;
    end else if (!a_at[e]) begin
      m_st = S_IDLE; m_lf = 1'b0; m_lk = 1'b0;
    end else if (m_st == S_IDLE || m_st == S_FAIL) begin
      if (s_at[e]) begin
        m_st = S_LOAD; m_lf = 1'b1; m_fq = f_at[e]; m_lg = LS; m_fl = 1'b0; m_retry = 0;
      end
    end else if (m_st == S_LOAD) begin
      m_st = S_ACQ; m_lf = 1'b0; m_ws = e + 1;
    end else if (e == m_ws + W - 1) begin
      total = 0;
      for (int k = m_ws; k <= e; k++) if (e_at[k] != 2'b00) total++;
      m_ws = e + 1;
      if (m_st == S_ACQ) begin
        if (total <= LT) begin
          if (m_lg == LF) begin
            m_st = S_LOCKED; m_lk = 1'b1;
          end else begin
            m_lg++;
          end
        end else begin
          m_retry++;
          if (m_retry == MR) begin
            m_st = S_FAIL; m_fl = 1'b1;
          end else begin
            m_st = S_LOAD; m_lf = 1'b1; m_fq = f_at[e]; m_lg = LS;
          end
        end
      end else if (total > 2 * LT) begin
        m_st = S_ACQ; m_lk = 1'b0; m_lg = LS; m_retry = 0;
      end
    end
    nxt = '{st: 3'(m_st), lf: m_lf, lg: 5'(m_lg), lk: m_lk, fl: m_fl, fq: m_fq};
    if (nxt !== m_prev) begin
      ev.e = e;
      ev.s = nxt;
      exp_q.push_back(ev);
      m_prev = nxt;
    end
  endtask

  task automatic applyStimulus(input int e);
    nrst        = r_at[e];
    swipt_alive = a_at[e];
    start       = s_at[e];
    init_freq   = f_at[e];
    pll_error   = e_at[e];
    model_step(e);
  endtask

  task automatic checkOutput();
    snap_t cur;
    exp_t  ex;
    cur = '{st: state, lf: load_freq, lg: lgcoefficient, lk: locked, fl: fail, fq: freq};
    if (cyc == 1) begin
      n_checks++;
      if (cur !== RESET_SNAP) begin
        n_fail++;
        $display("[TB] FAIL reset_values: got %s, required %s", show(cur), show(RESET_SNAP));
      end
    end else if (cur !== mon_prev) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL unexpected_change @%0d: got %s, required no change", cyc, show(cur));
      end else begin
        ex = exp_q.pop_front();
        if (ex.e != cyc || ex.s !== cur) begin
          n_fail++;
          $display("[TB] FAIL output_event: got @%0d %s, required @%0d %s",
                   cyc, show(cur), ex.e, show(ex.s));
        end
      end
    end
    mon_prev = cur;
  endtask

  always @(negedge clk) begin
    if (cyc >= 1 && !done) checkOutput();
  end

  initial begin
    exp_t ex;
    build_stimulus();
    m_st = S_IDLE; m_lf = 1'b0; m_fq = '0; m_lg = LS;
    m_lk = 1'b0; m_fl = 1'b0; m_retry = 0; m_ws = 0;
    m_prev = RESET_SNAP;
    applyStimulus(1);
    for (int e = 2; e <= N; e++) begin
      @(negedge clk);
      applyStimulus(e);
    end
    @(negedge clk);
    @(negedge clk);
    done = 1'b1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      ex = exp_q[0];
      $display("[TB] FAIL missing_events: got none of %0d pending, required @%0d %s",
               exp_q.size(), ex.e, show(ex.s));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
